input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//   Front end feeding the start/count integrator: cleans raw asynchronous
//   inputs before the ASM controller samples them. Produces one-cycle start
//   pulse S (one per press) and a debounced count-enable level X. Sits
//   directly upstream of the controller/counter. Rejects starts while the
//   controller is busy.
// PARAMETERS
//   SYNC_STAGES  2  synchronizer flops per raw input (>=2)
//   DEB_CYCLES   4  consecutive differing synced samples needed to flip a debounced level (>=1)
//   CNT_W        3  debounce counter width; 2**CNT_W > DEB_CYCLES
// PORTS
//   clk     in   1  system clock, all state on posedge
//   rst_n   in   1  asynchronous, active-low reset
//   s_raw   in   1  raw start request (async, may bounce)
//   x_raw   in   1  raw count input (async, may bounce)
//   busy    in   1  controller not idle (T1|T2); sync to clk
//   S       out  1  start pulse to controller, exactly 1 cycle
//   X       out  1  debounced count level to controller
//   s_drop  out  1  1-cycle flag: press rejected because busy
// BEHAVIOUR
//   Reset (rst_n=0, async, no clock needed): sync flops=0, cnt=0, deb_s=deb_x=0,
//     FSM=ARMED, S=X=s_drop=0. Release is internally synchronous.
//   Sync: each raw input passes through SYNC_STAGES flops; value valid after edge SYNC_STAGES.
//   Debounce, per channel, each edge: sync==deb -> cnt<=0;
//     sync!=deb & cnt<DEB_CYCLES-1 -> cnt<=cnt+1;
//     sync!=deb & cnt==DEB_CYCLES-1 -> deb<=sync, cnt<=0.
//     Any agreeing sample clears cnt; pulses shorter than DEB_CYCLES are lost.
//   Latency (defaults): raw change before edge 1 -> deb updates at edge
//     SYNC_STAGES+DEB_CYCLES = 6. X = deb_x (registered), so X changes after edge 6.
//   Start FSM (Moore, states ARMED, FIRE, WAIT_REL):
//     ARMED & deb_s & !busy -> FIRE;  ARMED & deb_s & busy -> WAIT_REL, s_drop<=1
//     FIRE -> WAIT_REL (always);      WAIT_REL & !deb_s -> ARMED
//     S=1 iff state==FIRE. s_drop is 1 for one cycle only.
//   busy is sampled only in ARMED on the edge deb_s is first seen high.
//     Busy dropping while still held does not fire S: re-press required.
//   One press = one S regardless of hold time; next S needs deb_s low, then high again.
//   s_raw high through reset: treated as a new press -> one S after debounce.
//   Reset mid-debounce or in FIRE: S dropped immediately, no pulse after release
//     unless the input is still/again high after full debounce.
//   Unused FSM encoding -> ARMED next edge.
// TESTING (SYNC_STAGES=2, DEB_CYCLES=4)
//   1 rst_n=0, s_raw=x_raw=1 -> S=X=s_drop=0 during reset. Release, inputs held
//     -> X=1 after edge 6, S=1 only in cycle after edge 7.
//   2 s_raw 0->1 held 20 cycles, busy=0 -> S high exactly 1 cycle (after edge 7).
//     Release >=6 cycles then re-press -> exactly one more S.
//   3 s_raw high 3 cycles only; x_raw toggles every cycle for 10 cycles then
//     stays 1 -> no S; X rises once, 6 edges after the last toggle.
//   4 busy=1, press s_raw -> S stays 0, s_drop=1 for one cycle (after edge 7).
//     busy->0 while held -> S stays 0.
//   5 rst_n asserted between clock edges mid-count (cnt=2) and while in FIRE
//     -> S, X, s_drop read 0 before the next edge.
//   6 x_raw 1 for 30 cycles then 0 -> X rises after edge 6, falls 6 edges after
//     the drop. S unaffected throughout.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Signal bundle between the raw input pins and the start/count controller.
// The DUT connects through the slave modport; the pin-side driver uses master.
interface input_conditioner_if;
    logic s_raw;
    logic x_raw;
    logic busy;
    logic S;
    logic X;
    logic s_drop;

    modport master (
        output s_raw,
        output x_raw,
        output busy,
        input  S,
        input  X,
        input  s_drop
    );

    modport slave (
        input  s_raw,
        input  x_raw,
        input  busy,
        output S,
        output X,
        output s_drop
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises and debounces the raw start/count inputs, turning each start
// press into a single-cycle S pulse (or an s_drop flag when the controller is busy).
module input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input_conditioner_if.slave   bus
);

    localparam logic [1:0] ARMED    = 2'b00;
    localparam logic [1:0] FIRE     = 2'b01;
    localparam logic [1:0] WAIT_REL = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync_s;
    logic [SYNC_STAGES-1:0] r_sync_x;
    logic [1:0]             w_sync;
    logic [CNT_W-1:0]       r_cnt [2];
    logic [1:0]             r_deb;
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic                   w_drop_nxt;
    logic                   r_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_s <= '0;
            r_sync_x <= '0;
        end else begin
            r_sync_s <= {r_sync_s[SYNC_STAGES-2:0], bus.s_raw};
            r_sync_x <= {r_sync_x[SYNC_STAGES-2:0], bus.x_raw};
        end
    end

    // Channel 0 = start, channel 1 = count.
    assign w_sync = {r_sync_x[SYNC_STAGES-1], r_sync_s[SYNC_STAGES-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                r_cnt[ch] <= '0;
            end
            r_deb <= '0;
        end else begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                if (w_sync[ch] == r_deb[ch]) begin
                    r_cnt[ch] <= '0;
                end else if (r_cnt[ch] < CNT_LAST) begin
                    r_cnt[ch] <= r_cnt[ch] + 1'b1;
                end else begin
                    r_deb[ch] <= w_sync[ch];
                    r_cnt[ch] <= '0;
                end
            end
        end
    end

    // busy only matters on the edge the debounced press is first seen in ARMED.
    always_comb begin
        w_state_nxt = ARMED;
        w_drop_nxt  = 1'b0;
        case (r_state)
            ARMED: begin
                if (r_deb[0]) begin
                    w_state_nxt = bus.busy ? WAIT_REL : FIRE;
                    w_drop_nxt  = bus.busy;
                end else begin
                    w_state_nxt = ARMED;
                end
            end
            FIRE:     w_state_nxt = WAIT_REL;
            WAIT_REL: w_state_nxt = r_deb[0] ? WAIT_REL : ARMED;
            default:  w_state_nxt = ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARMED;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    assign bus.S      = (r_state == FIRE);
    assign bus.X      = r_deb[1];
    assign bus.s_drop = r_drop;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (SYNC_STAGES=2, DEB_CYCLES=4): per-edge
// vector table plus hand-written reset sequences; expected values derive from the 6-edge latency.
module tb_input_conditioner;

    typedef struct {
        bit    rst;
        bit    s;
        bit    x;
        bit    b;
        bit    exp_s;
        bit    exp_x;
        bit    exp_d;
        string name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    vec_t vecs[$];

    input_conditioner_if bus ();

    input_conditioner #(
        .SYNC_STAGES(2),
        .DEB_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int idx, input logic act, input logic exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s idx=%0d: got %b expected %b", nm, idx, act, exp);
        else
            n_pass++;
    endtask

    task automatic check_all(input string nm, input int idx, input bit es, input bit ex, input bit ed);
        check({nm, ".S"}, idx, bus.S, es);
        check({nm, ".X"}, idx, bus.X, ex);
        check({nm, ".s_drop"}, idx, bus.s_drop, ed);
    endtask

    task automatic push(input bit r, input bit s, input bit x, input bit b,
                        input bit es, input bit ex, input bit ed, input string nm);
        vec_t v;
        v.rst = r; v.s = s; v.x = x; v.b = b;
        v.exp_s = es; v.exp_x = ex; v.exp_d = ed; v.name = nm;
        vecs.push_back(v);
    endtask

    // Reset with quiet inputs; release lands between edges so the next edge is edge 1.
    task automatic do_reset();
        bus.s_raw = 1'b0;
        bus.x_raw = 1'b0;
        bus.busy  = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.s_raw = 1'b0;
        bus.x_raw = 1'b0;
        bus.busy  = 1'b0;

        // Inputs high through reset count as a fresh press.
        #1;
        rst_n = 1'b0;
        bus.s_raw = 1'b1;
        bus.x_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all("in_reset", i, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            check_all("held_thru_reset", e, (e == 7), (e >= 6), 1'b0);
        end

        // Reset asserted between edges mid-debounce (cnt=2 after edge 4).
        do_reset();
        bus.s_raw = 1'b1;
        bus.x_raw = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("rst_mid_count", 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk);
            #1;
            check_all("after_mid_rst", e, (e == 7), (e >= 6), 1'b0);
        end
        // Now in FIRE with X high: reset must clear both before the next edge.
        #2;
        rst_n = 1'b0;
        bus.s_raw = 1'b0;
        bus.x_raw = 1'b0;
        #1;
        check_all("rst_in_fire", 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            check_all("after_fire_rst", e, 1'b0, 1'b0, 1'b0);
        end

        // Vector index k is applied before edge k+1 and checked just after it.
        for (int k = 0; k < 50; k++)
            push(k == 0, (k < 20) || (k >= 30), 1'b0, 1'b0,
                 (k + 1 == 7) || (k + 1 == 37), 1'b0, 1'b0, "press_twice");
        for (int k = 0; k < 25; k++)
            push(k == 0, (k < 3), (k < 10) ? (k % 2 == 0) : 1'b1, 1'b0,
                 1'b0, (k + 1 >= 16), 1'b0, "glitch_bounce");
        for (int k = 0; k < 25; k++)
            push(k == 0, 1'b1, 1'b0, (k < 8),
                 1'b0, 1'b0, (k + 1 == 7), "busy_reject");
        for (int k = 0; k < 45; k++)
            push(k == 0, 1'b0, (k < 30), 1'b0,
                 1'b0, (k + 1 >= 6) && (k + 1 < 36), 1'b0, "x_level");

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            bus.s_raw = vecs[i].s;
            bus.x_raw = vecs[i].x;
            bus.busy  = vecs[i].b;
            @(posedge clk);
            #1;
            check_all(vecs[i].name, i, vecs[i].exp_s, vecs[i].exp_x, vecs[i].exp_d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
